mpadder_arbiter: RTL
====================

# mpadder_arbiter

Round-robin arbiter and sequencer that shares one 1027-bit `mpadder` instance between up to four requesters, such as the Montgomery multiply loop and the final-reduction/exponentiation control in the RSA datapath. Each requester presents operands and an add/subtract flag. The block grants one requester at a time, drives the adder's start/operand port, and waits for the adder to finish. It then returns the 1028-bit result with a per-requester done pulse. The block sits between the requesters and the `mpadder` port; `mpadder` is instantiated beside it, not inside it.

## Interface
- `N_REQ`, 2: number of requesters, 2..4.
- `OPW`, 1027: operand width; result width is `OPW+1`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  request i pending; held until `req_ack[i]`; may be withdrawn before ack.
- `req_sub`  in  N_REQ  1 = subtract (a−b), 0 = add.
- `req_a`  in  N_REQ*OPW  flat operand A; slice i = `[i*OPW +: OPW]`.
- `req_b`  in  N_REQ*OPW  flat operand B.
- `req_ack`  out  N_REQ  one-cycle pulse: request i latched.
- `rsp_done`  out  N_REQ  one-cycle pulse: result for requester i valid.
- `rsp_result`  out  OPW+1  last result; held until the next completion.
- `busy`  out  1  high in every state other than IDLE.
- `adder_start`  out  1  start pulse to `mpadder`.
- `adder_subtract`  out  1  to `mpadder`.
- `adder_a`, `adder_b`  out  OPW  registered operands to `mpadder`.
- `adder_result`  in  OPW+1  from `mpadder`.
- `adder_done`  in  1  from `mpadder`; may stay high after completion.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any `req_valid` is high, grant g = first index with `req_valid` set, scanning cyclically from pointer `ptr`.
  - Latch slice g of `req_a`/`req_b`/`req_sub` into `adder_a`/`adder_b`/`adder_subtract` and store g.
  - Go to ISSUE.
- ISSUE (exactly 1 cycle): `adder_start`=1 and `req_ack[g]`=1; go to WAIT.
- WAIT:
  - Completion = rising edge of `adder_done`, i.e. `adder_done & ~done_q`. `done_q` registers `adder_done` every cycle in every state.
  - On completion: `rsp_result` ← `adder_result`; `rsp_done[g]`=1 in the next cycle; `ptr` ← (g+1) mod N_REQ; go to IDLE.
- `adder_done` edges seen in IDLE or ISSUE are ignored. A stale high `adder_done` from a previous operation never completes a new one.
- Withdrawal: `req_valid[i]` dropping before ack is legal; it is simply not granted.
- Operand registers stay stable from ISSUE until leaving WAIT.
- No width conversion; the result is passed through unchanged (subtract borrow is in bit OPW, as produced by `mpadder`).

## Timing
- Reset (async, immediate): state IDLE, `ptr`=0, `done_q`=0. All outputs are 0: `req_ack`, `rsp_done`, `rsp_result`, `busy`, `adder_start`, `adder_subtract`, `adder_a`, `adder_b`.
- Cycle 0: IDLE with `req_valid[i]` high.
- Cycle 1: ISSUE; `adder_start`=1, `req_ack[i]`=1, operands valid.
- Cycle 2 onward: WAIT.
- Rising edge of `adder_done` sampled in cycle k → cycle k+1: `rsp_done[g]`=1, `rsp_result` valid, state IDLE. A new grant can be made in cycle k+1, giving ISSUE in cycle k+2.
- Requester must deassert `req_valid` in the cycle after `req_ack`. If it is still high at the next IDLE, it is treated as a new request.
- Reset during ISSUE/WAIT: the operation is dropped, no `rsp_done` is issued, and the adder result is discarded.
- Overhead: 2 cycles of arbitration/issue per operation plus the adder latency.

## Structure
- Package `mpadder_pkg`: `OPW`=1027, `RESW`=1028, FSM state encoding (IDLE/ISSUE/WAIT), `MAX_REQ`=4.
- Sub-module `rr_grant`: combinational cyclic priority pick from (`req_valid`, `ptr`) → one-hot grant plus index.
- FSM, operand/result registers and the done edge detector live in the top module.

## Test plan
- Req0 add 1+1 alone → `req_ack[0]` and `adder_start` pulse the cycle after request with a=1, b=1, sub=0; `rsp_done[0]` with `rsp_result`=2; `rsp_done[1]` never asserts.
- Req1 sub 1−1 alone → `rsp_done[1]`, `rsp_result`=0, `ptr` becomes 0.
- Req0 and req1 both valid continuously after reset → grants alternate 0,1,0,1; `rsp_done` order matches; each requester's own operands are seen on `adder_a`/`adder_b`.
- Adder model holds `adder_done` high while idle, then req0 issued → no `rsp_done` until `adder_done` falls and rises again.
- Assert `rst` mid-WAIT → all outputs 0 immediately; no `rsp_done` for the dropped op; next req1 is granted and completes normally.
- Real `mpadder`, req0 add of two random 1027-bit vectors and req1 subtract giving a negative result → `rsp_result` equals the 1028-bit two's-complement result (e.g. 6fb7…518 − 716d…218 = fe49…300).

Source files
------------

// File: rtl/mpadder_pkg.sv
// Shared types and sizes for the mpadder arbiter: operand/result widths,
// requester limit and FSM state encoding.
package mpadder_pkg;

  localparam int OPW     = 1027;
  localparam int RESW    = OPW + 1;
  localparam int MAX_REQ = 4;
  localparam int IDXW    = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_grant.sv
// Combinational cyclic priority pick: first valid requester at or after ptr,
// returned both as a one-hot vector and as an index.
module rr_grant
  import mpadder_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDXW-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDXW-1:0]  idx,
  output logic             any
);

  localparam int CW = IDXW + 1;

  logic [MAX_REQ-1:0] valid_pad;
  logic [MAX_REQ-1:0] grant_pad;
  logic [CW-1:0]      cand;

  // Pad to MAX_REQ so a fixed-width index can address any requester.
  assign valid_pad = MAX_REQ'(req_valid);

  always_comb begin
    grant_pad = '0;
    idx       = '0;
    any       = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      if (!any && valid_pad[cand[IDXW-1:0]]) begin
        any                         = 1'b1;
        idx                         = cand[IDXW-1:0];
        grant_pad[cand[IDXW-1:0]]   = 1'b1;
      end
    end
  end

  assign grant = grant_pad[N_REQ-1:0];

endmodule

// File: rtl/mpadder_arbiter.sv
// Round-robin arbiter/sequencer sharing one external mpadder between up to
// four requesters; issues one operation at a time and returns its result.
module mpadder_arbiter
  import mpadder_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int OPW   = mpadder_pkg::OPW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_sub,
  input  logic [N_REQ*OPW-1:0] req_a,
  input  logic [N_REQ*OPW-1:0] req_b,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   rsp_done,
  output logic [OPW:0]       rsp_result,
  output logic               busy,
  output logic               adder_start,
  output logic               adder_subtract,
  output logic [OPW-1:0]     adder_a,
  output logic [OPW-1:0]     adder_b,
  input  logic [OPW:0]       adder_result,
  input  logic               adder_done
);

  state_t            state, next_state;
  logic [IDXW-1:0]   ptr;
  logic [IDXW-1:0]   g_q;
  logic [IDXW-1:0]   gsel;
  logic [N_REQ-1:0]  gvec;
  logic [N_REQ-1:0]  g_onehot;
  logic              any_req;
  logic              done_q;
  logic              complete;
  logic [OPW-1:0]    sel_a;
  logic [OPW-1:0]    sel_b;
  logic              sel_sub;

  rr_grant #(
    .N_REQ(N_REQ)
  ) u_grant (
    .req_valid(req_valid),
    .ptr      (ptr),
    .grant    (gvec),
    .idx      (gsel),
    .any      (any_req)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gvec[i]) begin
        sel_a = req_a[i*OPW +: OPW];
        sel_b = req_b[i*OPW +: OPW];
      end
    end
  end

  assign sel_sub  = |(req_sub & gvec);
  assign g_onehot = N_REQ'(1) << g_q;
  // Only a fresh rising edge of done while waiting counts; a level left high
  // by an earlier operation must never complete the current one.
  assign complete = (state == WAIT) && adder_done && !done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (complete) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    adder_start = (state == ISSUE);
    req_ack     = (state == ISSUE) ? g_onehot : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr            <= '0;
      g_q            <= '0;
      done_q         <= 1'b0;
      rsp_done       <= '0;
      rsp_result     <= '0;
      adder_a        <= '0;
      adder_b        <= '0;
      adder_subtract <= 1'b0;
    end else begin
      done_q   <= adder_done;
      rsp_done <= '0;
      if (state == IDLE && any_req) begin
        adder_a        <= sel_a;
        adder_b        <= sel_b;
        adder_subtract <= sel_sub;
        g_q            <= gsel;
      end
      if (complete) begin
        rsp_result <= adder_result;
        rsp_done   <= g_onehot;
        ptr        <= (g_q == IDXW'(N_REQ - 1)) ? '0 : g_q + IDXW'(1);
      end
    end
  end

endmodule
